// File: rtl/keypad_decoder.sv
// keypad_decoder: scans a 4x4 active-low matrix keypad, debounces the decoded
// key over whole scan frames, and conditions the START/RESTART buttons into
// synchronised, debounced levels. All outputs come straight from registers.

// Single-button conditioner: 2-FF synchroniser followed by a hold counter that
// only lets the output follow the synced level after it has been stable long enough.
module keypad_btn_debounce #(
   parameter int unsigned BTN_DEBOUNCE = 50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic level
);

   localparam int unsigned CNT_W = (BTN_DEBOUNCE > 2) ? $clog2(BTN_DEBOUNCE) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BTN_DEBOUNCE - 1);

   logic             s1_q, s2_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             out_q, out_d;

   // Synchronise the asynchronous button input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= btn;
         s2_q <= s1_q;
      end
   end

   // Count while the synced level disagrees with the output; toggle on terminal count.
   always_comb begin
      cnt_d = cnt_q;
      out_d = out_q;
      if (s2_q == out_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         out_d = s2_q;
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Hold counter and output level registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         out_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         out_q <= out_d;
      end
   end

   assign level = out_q;

endmodule

module keypad_decoder #(
   parameter int unsigned SCAN_DIV        = 1000,
   parameter int unsigned DEBOUNCE_FRAMES = 4,
   parameter int unsigned BTN_DEBOUNCE    = 50000
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [3:0] row,
   input  logic [3:0] col,
   input  logic       btn_start,
   input  logic       btn_restart,
   output logic [3:0] decode,
   output logic       key_valid,
   output logic       START,
   output logic       RESTART
);

   localparam int unsigned DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned STB_W = (DEBOUNCE_FRAMES > 1) ? $clog2(DEBOUNCE_FRAMES + 1) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [STB_W-1:0] STB_MAX  = STB_W'(DEBOUNCE_FRAMES);

   typedef enum logic {
      IDLE,
      PRESSED
   } state_e;

   // Key code for a row/column intersection.
   function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] code;
      case ({r, c})
         4'b00_00: code = 4'h1;
         4'b00_01: code = 4'h2;
         4'b00_10: code = 4'h3;
         4'b00_11: code = 4'hA;
         4'b01_00: code = 4'h4;
         4'b01_01: code = 4'h5;
         4'b01_10: code = 4'h6;
         4'b01_11: code = 4'hB;
         4'b10_00: code = 4'h7;
         4'b10_01: code = 4'h8;
         4'b10_10: code = 4'h9;
         4'b10_11: code = 4'hC;
         4'b11_00: code = 4'hE;
         4'b11_01: code = 4'h0;
         4'b11_10: code = 4'hF;
         default:  code = 4'hD;
      endcase
      return code;
   endfunction

   // Column synchroniser
   logic [3:0]       col_s1_q, col_s2_q;
   // Scan timing
   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [1:0]       row_idx_q, row_idx_d;
   logic [3:0]       row_q, row_d;
   logic             sample_en, frame_end;
   // Frame accumulation: hit count saturates at 2 (= multi-key)
   logic [1:0]       acc_n_q, acc_n_d;
   logic [3:0]       acc_code_q, acc_code_d;
   logic [1:0]       row_hit_n;
   logic [1:0]       row_hit_col;
   logic [1:0]       tot_n;
   logic [3:0]       tot_code;
   logic [4:0]       frame_res;
   // Debounce
   state_e           state_q, state_d;
   logic [4:0]       prev_res_q, prev_res_d;
   logic [STB_W-1:0] stable_cnt_q, stable_cnt_d;
   logic             take;
   logic [3:0]       decode_q, decode_d;
   logic             key_valid_q, key_valid_d;

   // Synchronise the column sense lines; reset to the released (pulled-up) level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_s1_q <= '1;
         col_s2_q <= '1;
      end else begin
         col_s1_q <= col;
         col_s2_q <= col_s1_q;
      end
   end

   assign sample_en = (div_cnt_q == DIV_LAST);
   assign frame_end = sample_en && (row_idx_q == 2'd3);

   // Row divider, row index and one-cold row drive rotation.
   always_comb begin
      div_cnt_d = div_cnt_q + 1'b1;
      row_idx_d = row_idx_q;
      row_d     = row_q;
      if (sample_en) begin
         div_cnt_d = '0;
         row_idx_d = row_idx_q + 2'd1;
         row_d     = {row_q[2:0], row_q[3]};
      end
   end

   // Classify the currently driven row: no hit, one hit (with column) or several.
   always_comb begin
      row_hit_n   = 2'd0;
      row_hit_col = 2'd0;
      for (int unsigned c = 0; c < 4; c++) begin
         if (!col_s2_q[c]) begin
            if (row_hit_n == 2'd0) begin
               row_hit_n   = 2'd1;
               row_hit_col = 2'(c);
            end else begin
               row_hit_n = 2'd2;
            end
         end
      end
   end

   // Merge this row's hits into the running frame tally and form the frame result.
   always_comb begin
      tot_n    = 2'd2;
      tot_code = 4'h0;
      if (acc_n_q == 2'd0) begin
         tot_n    = row_hit_n;
         tot_code = key_code(row_idx_q, row_hit_col);
      end else if (row_hit_n == 2'd0) begin
         tot_n    = acc_n_q;
         tot_code = acc_code_q;
      end
      frame_res = (tot_n == 2'd1) ? {1'b1, tot_code} : 5'b0_0000;
      acc_n_d    = acc_n_q;
      acc_code_d = acc_code_q;
      if (frame_end) begin
         acc_n_d    = 2'd0;
         acc_code_d = 4'h0;
      end else if (sample_en) begin
         acc_n_d    = tot_n;
         acc_code_d = tot_code;
      end
   end

   // Scan and frame accumulation registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q  <= '0;
         row_idx_q  <= 2'd0;
         row_q      <= 4'b1110;
         acc_n_q    <= 2'd0;
         acc_code_q <= 4'h0;
      end else begin
         div_cnt_q  <= div_cnt_d;
         row_idx_q  <= row_idx_d;
         row_q      <= row_d;
         acc_n_q    <= acc_n_d;
         acc_code_q <= acc_code_d;
      end
   end

   // Debounce FSM state register with its frame-history bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         prev_res_q   <= 5'b0_0000;
         stable_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         prev_res_q   <= prev_res_d;
         stable_cnt_q <= stable_cnt_d;
      end
   end

   // Next state: count identical consecutive frames and adopt a result once stable.
   always_comb begin
      state_d      = state_q;
      prev_res_d   = prev_res_q;
      stable_cnt_d = stable_cnt_q;
      take         = 1'b0;
      if (frame_end) begin
         prev_res_d = frame_res;
         if (frame_res == prev_res_q) begin
            stable_cnt_d = (stable_cnt_q == STB_MAX) ? STB_MAX : stable_cnt_q + 1'b1;
         end else begin
            stable_cnt_d = STB_W'(1);
         end
         take = (stable_cnt_d == STB_MAX) && (frame_res != {key_valid_q, decode_q});
         if (take) begin
            state_d = frame_res[4] ? PRESSED : IDLE;
         end
      end
   end

   // Outputs: decode and key_valid update together, only when a result is adopted.
   always_comb begin
      decode_d    = decode_q;
      key_valid_d = key_valid_q;
      if (take) begin
         key_valid_d = (state_d == PRESSED);
         decode_d    = (state_d == PRESSED) ? frame_res[3:0] : 4'h0;
      end
   end

   // Registered key outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         decode_q    <= 4'h0;
         key_valid_q <= 1'b0;
      end else begin
         decode_q    <= decode_d;
         key_valid_q <= key_valid_d;
      end
   end

   keypad_btn_debounce #(
      .BTN_DEBOUNCE(BTN_DEBOUNCE)
   ) u_btn_start (
      .clk  (clk),
      .rst_n(rst_n),
      .btn  (btn_start),
      .level(START)
   );

   keypad_btn_debounce #(
      .BTN_DEBOUNCE(BTN_DEBOUNCE)
   ) u_btn_restart (
      .clk  (clk),
      .rst_n(rst_n),
      .btn  (btn_restart),
      .level(RESTART)
   );

   assign row       = row_q;
   assign decode    = decode_q;
   assign key_valid = key_valid_q;

endmodule

// File: tb/tb_keypad_decoder.sv
// tb_keypad_decoder: drives a behavioural 4x4 keypad and two buttons into
// keypad_decoder and checks decode/key_valid and START/RESTART against a
// queue of expected events pushed as the stimulus is applied.
module tb_keypad_decoder;

   localparam int unsigned SCAN_DIV   = 4;
   localparam int unsigned DEB_FRAMES = 3;
   localparam int unsigned BTN_DEB    = 8;
   localparam int          KEY_BUDGET = (DEB_FRAMES + 1) * 4 * SCAN_DIV + 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] row, col, decode;
   logic       key_valid, START, RESTART;
   logic       btn_start = 1'b0;
   logic       btn_restart = 1'b0;
   logic [15:0] pressed = '0;

   int n_checks = 0;
   int n_errors = 0;

   logic [4:0] exp_key_q[$];
   logic       exp_btn_q[$];

   always #5 clk = ~clk;

   // Keypad matrix: a pressed key pulls its column low while its row is driven low.
   always_comb begin
      col = 4'hF;
      for (int r = 0; r < 4; r++) begin
         if (!row[r]) begin
            for (int c = 0; c < 4; c++) begin
               if (pressed[r*4+c]) col[c] = 1'b0;
            end
         end
      end
   end

   keypad_decoder #(
      .SCAN_DIV       (SCAN_DIV),
      .DEBOUNCE_FRAMES(DEB_FRAMES),
      .BTN_DEBOUNCE   (BTN_DEB)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .row        (row),
      .col        (col),
      .btn_start  (btn_start),
      .btn_restart(btn_restart),
      .decode     (decode),
      .key_valid  (key_valid),
      .START      (START),
      .RESTART    (RESTART)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] kbit(input int r, input int c);
      logic [15:0] one;
      one = 16'd1;
      return one << (r * 4 + c);
   endfunction

   // Wait (bounded) for the key outputs to change, then compare with the next expected event.
   task automatic wait_key(input string tag);
      logic [4:0] start_v, cur, exp;
      int n;
      start_v = {key_valid, decode};
      cur = start_v;
      n = 0;
      while (cur == start_v && n < KEY_BUDGET) begin
         @(negedge clk);
         n++;
         cur = {key_valid, decode};
      end
      exp = exp_key_q.pop_front();
      check_eq(tag, 32'(cur), 32'(exp));
   endtask

   // Key outputs must hold a given value for n cycles; report the first deviation.
   task automatic hold_key(input string tag, input int n, input logic [4:0] exp);
      logic [4:0] seen;
      seen = exp;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (seen == exp && {key_valid, decode} != exp) seen = {key_valid, decode};
      end
      check_eq(tag, 32'(seen), 32'(exp));
   endtask

   // Wait (bounded) for a button level to rise; compare level and latency.
   task automatic wait_btn(input string tag, input bit which_restart);
      int n;
      logic lvl, exp;
      n = 0;
      lvl = which_restart ? RESTART : START;
      while (!lvl && n < 20) begin
         @(negedge clk);
         n++;
         lvl = which_restart ? RESTART : START;
      end
      exp = exp_btn_q.pop_front();
      check_eq({tag, "_level"}, 32'(lvl), 32'(exp));
      check_eq({tag, "_latency_in_8_11"}, 32'(n >= 8 && n <= 11), 32'd1);
   endtask

   initial begin
      logic [3:0] er;
      logic       seen_start;

      // Reset state
      repeat (3) @(negedge clk);
      check_eq("reset_state", 32'({row, key_valid, decode, START, RESTART}),
               32'({4'b1110, 1'b0, 4'h0, 1'b0, 1'b0}));
      rst_n = 1'b1;

      // Idle scan: row rotates every SCAN_DIV cycles, key outputs stay idle
      for (int k = 1; k <= 64; k++) begin
         @(negedge clk);
         er = ~(4'b0001 << ((k / 4) % 4));
         check_eq("idle_scan", 32'({row, key_valid, decode}), 32'({er, 1'b0, 4'h0}));
      end

      // Press and release '3'
      pressed = kbit(0, 2);
      exp_key_q.push_back({1'b1, 4'h3});
      wait_key("press_3");
      hold_key("hold_3", 40, {1'b1, 4'h3});
      pressed = '0;
      exp_key_q.push_back({1'b0, 4'h0});
      wait_key("release_3");

      // Roll from 'B' to 'C' without release
      pressed = kbit(1, 3);
      exp_key_q.push_back({1'b1, 4'hB});
      wait_key("press_B");
      pressed = kbit(2, 3);
      exp_key_q.push_back({1'b1, 4'hC});
      wait_key("roll_B_to_C");
      pressed = '0;
      exp_key_q.push_back({1'b0, 4'h0});
      wait_key("release_C");

      // Key '0' is distinguished from idle; a second key makes a multi-key frame
      pressed = kbit(3, 1);
      exp_key_q.push_back({1'b1, 4'h0});
      wait_key("press_0");
      pressed = kbit(3, 1) | kbit(1, 1);
      exp_key_q.push_back({1'b0, 4'h0});
      wait_key("multi_0_5");
      pressed = '0;
      hold_key("idle_after_multi", 40, {1'b0, 4'h0});

      // Short bounce ('*' pressed for a few cycles only) must not reach decode
      @(negedge clk);
      pressed = kbit(3, 0);
      repeat (5) @(negedge clk);
      pressed = '0;
      hold_key("bounce_ignored", 80, {1'b0, 4'h0});

      // START bounce then stable high
      seen_start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         btn_start = ~btn_start;
         for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            if (START) seen_start = 1'b1;
         end
      end
      check_eq("start_during_bounce", 32'(seen_start), 32'd0);
      btn_start = 1'b1;
      exp_btn_q.push_back(1'b1);
      wait_btn("start", 1'b0);

      // RESTART is independent of START
      btn_restart = 1'b1;
      exp_btn_q.push_back(1'b1);
      wait_btn("restart", 1'b1);
      check_eq("start_still_high", 32'(START), 32'd1);

      // Asynchronous reset while 'A' is decoded
      pressed = kbit(0, 3);
      exp_key_q.push_back({1'b1, 4'hA});
      wait_key("press_A");
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_eq("async_reset", 32'({row, key_valid, decode, START, RESTART}),
               32'({4'b1110, 1'b0, 4'h0, 1'b0, 1'b0}));

      // Scan restarts from row 0 after reset with no stale key
      pressed = '0;
      btn_start = 1'b0;
      btn_restart = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         er = ~(4'b0001 << ((k / 4) % 4));
         check_eq("restart_scan", 32'({row, key_valid, decode}), 32'({er, 1'b0, 4'h0}));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
